axi4_burst_master: RTL
======================

// Module: axi4_burst_master
// PURPOSE
//  Synthesisable AXI4 master engine; next generation of the sim-only AXI4 write/read tasks.
//  Turns one command (write|read, addr, len) into a full INCR burst on m_axi.
//  Write data arrives on a valid/ready stream; read data leaves on one.
//  One transaction in flight. Used by DMA/test logic to reach AXI4 slaves on the RFSoC fabric.
// PARAMETERS
//  ADDR_W   32   address width
//  DATA_W   256  data width; power of 2, 8..1024; awsize/arsize = log2(DATA_W/8)
//  ID_W     1    AXI ID width; awid = 0, arid = 1 (zero-extended)
// PORTS
//  axi_aclk                 in   1       clock
//  axi_areset               in   1       async reset, active-high
//  cmd_valid/cmd_ready      in/out 1     command handshake
//  cmd_write                in   1       1 = write burst, 0 = read burst
//  cmd_addr                 in   ADDR_W  start byte address (DATA_W/8 aligned)
//  cmd_len                  in   8       beats-1 (AXI len encoding)
//  wr_valid/wr_ready        in/out 1     write-data stream handshake
//  wr_data                  in   DATA_W  write beat
//  rd_valid/rd_ready        out/in 1     read-data stream handshake
//  rd_data                  out  DATA_W  read beat
//  rd_last                  out  1       last beat of read burst
//  done_valid               out  1       1-cycle pulse: transaction finished
//  done_resp                out  2       final response (see BEHAVIOUR)
//  m_axi_aw{id,addr,len,size,burst,lock,cache,prot,qos,region,valid}/awready  AXI4 AW
//  m_axi_w{data,strb,last,valid}/wready   AXI4 W (wstrb = all ones)
//  m_axi_b{resp,valid}/bready             AXI4 B
//  m_axi_ar{id,addr,len,size,burst,lock,cache,prot,qos,region,valid}/arready  AXI4 AR
//  m_axi_r{data,resp,last,valid}/rready   AXI4 R
// BEHAVIOUR
//  - Reset: state IDLE; awvalid/wvalid/bready/arvalid/rready/done_valid = 0; done_resp = 0;
//    beat_cnt = 0. Mid-burst reset aborts immediately; all valids drop asynchronously.
//  - Constant fields: burst = 2'b01 (INCR); lock/cache/prot/qos/region = 0.
//  - FSM: IDLE -> AW -> W -> B -> DONE -> IDLE (write); IDLE -> AR -> R -> DONE -> IDLE (read).
//  - IDLE: cmd_ready = 1. On cmd_valid&cmd_ready, latch addr/len/write, beat_cnt = 0, clear resp.
//  - AW/AR: awvalid/arvalid registered high the cycle after accept; addr/len stable.
//    Held until awready/arready is sampled high; AXI handshake rules apply.
//  - W: m_axi_wvalid = wr_valid, wr_ready = m_axi_wready, wdata = wr_data (combinational
//    pass-through, only while in W). wlast = (beat_cnt == len). Each handshake increments
//    beat_cnt; the handshake with wlast -> B. len = 0 gives a single beat with wlast = 1.
//  - B: bready = 1; on bvalid capture bresp -> DONE.
//  - R: rready = rd_ready, rd_valid = rvalid, rd_data/rd_last = rdata/rlast (pass-through).
//    done_resp keeps the highest rresp value seen. The rlast handshake -> DONE.
//    If beat_cnt != len at rlast, done_resp is forced to 2'b10.
//  - DONE: done_valid = 1 for exactly one cycle, done_resp stable; next cycle IDLE.
//  - Command-to-AW/AR latency: 1 cycle. Back-to-back command spacing: at least 1 cycle after done_valid.
//  - wr_ready/rd_valid = 0 outside W/R; wr_data ignored outside W; stream stalls are legal anywhere.
// CONFIGURATION
//  AXI4_BURST_MASTER_4K_CHECK_EN defined: on accept, if addr[11:0] + (len+1)*DATA_W/8 > 4096,
//    no AW/AR is issued; the FSM goes IDLE -> DONE with done_resp = 2'b10; write data is not consumed.
//  Undefined: no check; the command is issued as given (the caller must respect the 4 KB rule).
// TESTING
//  1 write addr 0x100, len 3, data 1..4, slave awready delayed 2 cycles -> 4 W beats, wlast on 4th,
//    done_resp 2'b00
//  2 read addr 0x100, len 3 -> rd_data 1..4, rd_last on 4th, done_valid 1 cycle, done_resp 2'b00
//  3 read len 7, rd_ready toggled every cycle, slave rresp 2'b10 on beat 5 -> all 8 beats delivered,
//    done_resp 2'b10
//  4 len 0 write, wr_valid withheld 5 cycles -> wvalid low until then, single beat with wlast = 1
//  5 slave rlast on beat 3 of len 7 -> done_resp 2'b10, FSM back to IDLE, cmd_ready = 1
//  6 4K_CHECK_EN: write addr 0xFE0, len 1, DATA_W 256 -> no awvalid, done_resp 2'b10 within 2 cycles;
//    assert axi_areset mid-W -> wvalid 0 at once, cmd_ready 1 after release

Source files
------------

// File: rtl/axi4_burst_master.sv
// axi4_burst_master: one-outstanding AXI4 INCR burst engine; optional 4 KB guard via AXI4_BURST_MASTER_4K_CHECK_EN
module axi4_burst_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256,
  parameter int ID_W = 1
) (
  input  logic                axi_aclk,
  input  logic                axi_areset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [7:0]          cmd_len,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_last,
  output logic                done_valid,
  output logic [1:0]          done_resp,
  output logic [ID_W-1:0]     m_axi_awid,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_awlock,
  output logic [3:0]          m_axi_awcache,
  output logic [2:0]          m_axi_awprot,
  output logic [3:0]          m_axi_awqos,
  output logic [3:0]          m_axi_awregion,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ID_W-1:0]     m_axi_arid,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [7:0]          m_axi_arlen,
  output logic [2:0]          m_axi_arsize,
  output logic [1:0]          m_axi_arburst,
  output logic                m_axi_arlock,
  output logic [3:0]          m_axi_arcache,
  output logic [2:0]          m_axi_arprot,
  output logic [3:0]          m_axi_arqos,
  output logic [3:0]          m_axi_arregion,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rlast,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);
  localparam int BYTES = DATA_W / 8;
  localparam logic [2:0] SIZE = 3'($clog2(BYTES));
  typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, DONE} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0] len_q, beat_cnt;
  logic [1:0] resp_q;
  logic over4k, w_hs, r_hs;
`ifdef AXI4_BURST_MASTER_4K_CHECK_EN
  assign over4k = 17'(cmd_addr[11:0]) + (17'(cmd_len) + 17'd1) * 17'(BYTES) > 17'd4096;
`else
  assign over4k = 1'b0;
`endif
  assign cmd_ready = state == IDLE;
  assign m_axi_awid = '0;
  assign m_axi_awaddr = addr_q;
  assign m_axi_awlen = len_q;
  assign m_axi_awsize = SIZE;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock = 1'b0;
  assign m_axi_awcache = '0;
  assign m_axi_awprot = '0;
  assign m_axi_awqos = '0;
  assign m_axi_awregion = '0;
  assign m_axi_awvalid = state == AW;
  assign m_axi_wvalid = state == W && wr_valid;
  assign wr_ready = state == W && m_axi_wready;
  assign m_axi_wdata = state == W ? wr_data : '0;
  assign m_axi_wstrb = '1;
  assign m_axi_wlast = state == W && beat_cnt == len_q;
  assign m_axi_bready = state == B;
  assign m_axi_arid = ID_W'(1);
  assign m_axi_araddr = addr_q;
  assign m_axi_arlen = len_q;
  assign m_axi_arsize = SIZE;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock = 1'b0;
  assign m_axi_arcache = '0;
  assign m_axi_arprot = '0;
  assign m_axi_arqos = '0;
  assign m_axi_arregion = '0;
  assign m_axi_arvalid = state == AR;
  assign m_axi_rready = state == R && rd_ready;
  assign rd_valid = state == R && m_axi_rvalid;
  assign rd_data = m_axi_rdata;
  assign rd_last = state == R && m_axi_rlast;
  assign done_valid = state == DONE;
  assign done_resp = resp_q;
  assign w_hs = m_axi_wvalid && m_axi_wready;
  assign r_hs = m_axi_rvalid && m_axi_rready;
  // state register; reset aborts any burst and drops every valid at once
  always_ff @(posedge axi_aclk or posedge axi_areset)
    if (axi_areset) state <= IDLE;
    else state <= state_n;
  // phase sequencing driven by command, address, data and response handshakes
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (cmd_valid) state_n = over4k ? DONE : cmd_write ? AW : AR;
      AW: if (m_axi_awready) state_n = W;
      W: if (w_hs && m_axi_wlast) state_n = B;
      B: if (m_axi_bvalid) state_n = DONE;
      AR: if (m_axi_arready) state_n = R;
      R: if (r_hs && m_axi_rlast) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // command latch, beat counting and final response accumulation
  always_ff @(posedge axi_aclk or posedge axi_areset)
    if (axi_areset) begin
      addr_q <= '0;
      len_q <= '0;
      beat_cnt <= '0;
      resp_q <= '0;
    end else begin
      if (state == IDLE && cmd_valid) begin
        addr_q <= cmd_addr;
        len_q <= cmd_len;
        beat_cnt <= '0;
        resp_q <= over4k ? 2'b10 : 2'b00;
      end
      if (w_hs || r_hs) beat_cnt <= beat_cnt + 8'd1;
      if (state == B && m_axi_bvalid) resp_q <= m_axi_bresp;
      if (r_hs) resp_q <= m_axi_rlast && beat_cnt != len_q ? 2'b10 : m_axi_rresp > resp_q ? m_axi_rresp : resp_q;
    end
endmodule
